// File: rtl/cache_pkg.sv
// Shared constants and types for the direct-mapped cache miss handler.
// Address is {tag, index}; a block is four words aligned on adr[1:0].
package cache_pkg;
  localparam int WORD     = 32;
  localparam int ADDRESSL = 12;
  localparam int TAG      = 3;
  localparam int BLOCKL   = 4;
  localparam int CNTW     = 16;
  localparam int AW       = ADDRESSL + TAG;

  typedef logic [AW-1:0] adr_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FETCH,
    FILL
  } state_e;
endpackage

// File: rtl/cache_miss_handler_block_buffer.sv
// Refill staging buffer: one word per RAM handshake, whole block out.
// Cleared on reset so an aborted refill leaves nothing behind.
module block_buffer
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [1:0]             idx,
  input  logic [WORD-1:0]        wdata,
  output logic [BLOCKL*WORD-1:0] data
);
  logic [WORD-1:0] word_q [BLOCKL];
  logic [WORD-1:0] word_d [BLOCKL];

  always_comb begin
    word_d = word_q;
    if (we) word_d[idx] = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) word_q <= '{default: '0};
    else      word_q <= word_d;
  end

  for (genvar g = 0; g < BLOCKL; g++) begin : g_flat
    assign data[g*WORD +: WORD] = word_q[g];
  end
endmodule

// File: rtl/cache_miss_handler.sv
// Miss controller: looks up CPU reads, refills a 4-word block from RAM
// on a miss, writes it to the cache in one cycle and retries the lookup.
module cache_miss_handler #(
  parameter int CNTW = cache_pkg::CNTW
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cpu_req,
  input  logic [cache_pkg::AW-1:0]               cpu_adr,
  output logic                                   cpu_ready,
  output logic                                   busy,
  input  logic                                   cache_hit,
  output logic [cache_pkg::AW-1:0]               address,
  output logic                                   c_read,
  output logic                                   c_write,
  output logic [cache_pkg::AW-1:0]               adr0,
  output logic [cache_pkg::AW-1:0]               adr1,
  output logic [cache_pkg::AW-1:0]               adr2,
  output logic [cache_pkg::AW-1:0]               adr3,
  output logic [cache_pkg::BLOCKL*cache_pkg::WORD-1:0] data_rtoc,
  output logic                                   mem_req,
  output logic [cache_pkg::AW-1:0]               mem_adr,
  input  logic                                   mem_ack,
  input  logic [cache_pkg::WORD-1:0]             mem_rdata,
  output logic [CNTW-1:0]                        misses
);
  import cache_pkg::*;

  state_e          state_q, state_d;
  adr_t            adr_q, adr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [CNTW-1:0] miss_q, miss_d;
  logic            buf_we;
  logic [BLOCKL*WORD-1:0] buf_data;

  block_buffer u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .idx   (cnt_q),
    .wdata (mem_rdata),
    .data  (buf_data)
  );

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    cnt_d     = cnt_q;
    miss_d    = miss_q;
    buf_we    = 1'b0;
    cpu_ready = 1'b0;
    c_read    = 1'b0;
    c_write   = 1'b0;
    mem_req   = 1'b0;
    address   = '0;
    mem_adr   = '0;
    adr0      = '0;
    adr1      = '0;
    adr2      = '0;
    adr3      = '0;
    data_rtoc = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          adr_d   = cpu_adr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        address   = adr_q;
        c_read    = 1'b1;
        cpu_ready = cache_hit;
        if (cache_hit) begin
          state_d = IDLE;
        end else begin
          if (!(&miss_q)) miss_d = miss_q + CNTW'(1);
          cnt_d   = 2'd0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        address = adr_q;
        mem_req = 1'b1;
        mem_adr = {adr_q[AW-1:2], cnt_q};
        if (mem_ack) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = FILL;
        end
      end
      FILL: begin
        address   = adr_q;
        c_write   = 1'b1;
        adr0      = {adr_q[AW-1:2], 2'd0};
        adr1      = {adr_q[AW-1:2], 2'd1};
        adr2      = {adr_q[AW-1:2], 2'd2};
        adr3      = {adr_q[AW-1:2], 2'd3};
        data_rtoc = buf_data;
        state_d   = LOOKUP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      cnt_q   <= 2'd0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign misses = miss_q;
endmodule

// File: tb/tb_cache_miss_handler.sv
// Scoreboard bench for cache_miss_handler with cache and RAM models.
// Miss counter is narrowed to 4 bits so saturation is reachable.
module tb_cache_miss_handler;
  localparam int W  = 32;
  localparam int AW = 15;
  localparam int CW = 4;

  logic            clk;
  logic            rst;
  logic            cpu_req;
  logic [AW-1:0]   cpu_adr;
  logic            cpu_ready;
  logic            busy;
  logic            cache_hit;
  logic [AW-1:0]   address;
  logic            c_read;
  logic            c_write;
  logic [AW-1:0]   adr0, adr1, adr2, adr3;
  logic [4*W-1:0]  data_rtoc;
  logic            mem_req;
  logic [AW-1:0]   mem_adr;
  logic            mem_ack;
  logic [W-1:0]    mem_rdata;
  logic [CW-1:0]   misses;

  cache_miss_handler #(.CNTW(CW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_adr(cpu_adr),
    .cpu_ready(cpu_ready), .busy(busy),
    .cache_hit(cache_hit), .address(address),
    .c_read(c_read), .c_write(c_write),
    .adr0(adr0), .adr1(adr1), .adr2(adr2), .adr3(adr3),
    .data_rtoc(data_rtoc),
    .mem_req(mem_req), .mem_adr(mem_adr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .misses(misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ram(input logic [AW-1:0] a);
    return {17'h1A5C3, a} ^ {a, 17'h0B71D};
  endfunction

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic flag(input string n);
    checks++;
    errors++;
    $display("FAIL %s: got event want none", n);
  endtask

  // Cache storage, written only by observed c_write strobes
  logic         vld  [4096];
  logic [2:0]   ctag [4096];
  logic [W-1:0] cdat [4096];
  assign cache_hit = c_read && vld[address[11:0]]
                     && (ctag[address[11:0]] == address[14:12]);

  // Reference model: resident tag per block index, saturating count
  logic [2:0] rtag [int];
  int rmiss = 0;

  typedef struct {
    int          lat;
    int          mis;
    logic [14:0] adr;
  } rdy_t;

  rdy_t        exp_rdy  [$];
  logic [14:0] exp_mem  [$];
  logic [14:0] exp_fill [$];
  logic [14:0] used     [$];
  int issue_cyc = 0;
  int lat_cfg = 0;

  // RAM responder with lat_cfg wait cycles per word
  initial begin
    int w;
    w = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (w >= lat_cfg) begin
          mem_ack = 1'b1;
          mem_rdata = ram(mem_adr);
          w = 0;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
          w++;
        end
      end else begin
        w = 0;
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: samples just before each rising edge
  logic [14:0] fb;
  rdy_t        rr;
  always @(negedge clk) begin
    #4;
    if (rst) begin
      if (mem_req) begin
        if (exp_mem.size() == 0) flag("unexpected mem_req");
        else begin
          chk("mem_adr", mem_adr, exp_mem[0]);
          if (mem_ack) void'(exp_mem.pop_front());
        end
      end
      if (c_write) begin
        if (exp_fill.size() == 0) flag("unexpected c_write");
        else begin
          fb = exp_fill.pop_front();
          chk("adr0", adr0, fb);
          chk("adr1", adr1, fb + 15'd1);
          chk("adr2", adr2, fb + 15'd2);
          chk("adr3", adr3, fb + 15'd3);
          for (int k = 0; k < 4; k++) begin
            chk($sformatf("data_rtoc w%0d", k),
                data_rtoc[k*W +: W], ram(fb + 15'(k)));
            vld[fb[11:0] + 12'(k)]  = 1'b1;
            ctag[fb[11:0] + 12'(k)] = fb[14:12];
            cdat[fb[11:0] + 12'(k)] = data_rtoc[k*W +: W];
          end
        end
      end
      if (cpu_ready) begin
        if (exp_rdy.size() == 0) flag("unexpected cpu_ready");
        else begin
          rr = exp_rdy.pop_front();
          chk("latency", cyc - issue_cyc, rr.lat);
          chk("misses", misses, rr.mis);
          chk("busy at ready", busy, 1);
          chk("cached word", cdat[rr.adr[11:0]], ram(rr.adr));
        end
      end
    end
  end

  task automatic push_miss(input logic [14:0] a);
    for (int k = 0; k < 4; k++) exp_mem.push_back({a[14:2], 2'(k)});
    exp_fill.push_back({a[14:2], 2'b00});
  endtask

  // Caller is at a falling edge; returns at the falling edge of the idle cycle
  task automatic issue(input logic [14:0] a, input int l);
    logic hit;
    int   bi;
    int   n;
    rdy_t e;
    bi  = int'(a[11:2]);
    hit = rtag.exists(bi) && (rtag[bi] == a[14:12]);
    lat_cfg = l;
    if (!hit) begin
      rtag[bi] = a[14:12];
      if (rmiss < (1 << CW) - 1) rmiss++;
      push_miss(a);
    end
    e.lat = hit ? 1 : 7 + 4 * l;
    e.mis = rmiss;
    e.adr = a;
    exp_rdy.push_back(e);
    used.push_back(a);
    cpu_req = 1'b1;
    cpu_adr = a;
    issue_cyc = cyc;
    @(negedge clk);
    cpu_adr = 15'($urandom);
    n = 0;
    while (!cpu_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) flag("cpu_ready timeout");
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset(input string t);
    chk({t, " cpu_ready"}, cpu_ready, 0);
    chk({t, " c_read"}, c_read, 0);
    chk({t, " c_write"}, c_write, 0);
    chk({t, " mem_req"}, mem_req, 0);
    chk({t, " busy"}, busy, 0);
    chk({t, " misses"}, misses, 0);
    chk({t, " address"}, address, 0);
    chk({t, " mem_adr"}, mem_adr, 0);
    chk({t, " adr3"}, adr3, 0);
    chk({t, " data_rtoc"}, longint'(|data_rtoc), 0);
  endtask

  // Reset lands in FETCH after two words have been accepted
  task automatic abort_test(input logic [14:0] a);
    int acks;
    int n;
    acks = 0;
    n = 0;
    lat_cfg = 1;
    push_miss(a);
    cpu_req = 1'b1;
    cpu_adr = a;
    while (acks < 2 && n < 100) begin
      @(negedge clk);
      #4;
      if (mem_req && mem_ack) acks++;
      n++;
    end
    if (acks < 2) flag("abort ack timeout");
    @(negedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk_reset("abort");
    exp_mem.delete();
    exp_fill.delete();
    rmiss = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [14:0] a;
    for (int i = 0; i < 4096; i++) begin
      vld[i] = 1'b0;
      ctag[i] = '0;
      cdat[i] = '0;
    end
    cpu_req = 1'b0;
    cpu_adr = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset("init");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      vld[12'h120 + 12'(k)]  = 1'b1;
      ctag[12'h120 + 12'(k)] = 3'd0;
      cdat[12'h120 + 12'(k)] = ram(15'h0120 + 15'(k));
    end
    rtag[int'(12'h120 >> 2)] = 3'd0;

    issue(15'h0123, 0);
    issue(15'h1235, 0);
    issue(15'h1235, 2);
    issue(15'h7FFF, 3);
    abort_test(15'h0456);
    issue(15'h0456, 0);
    issue(15'h0457, 1);

    repeat (40) begin
      if ($urandom_range(0, 1) == 1)
        a = used[$urandom_range(0, used.size() - 1)];
      else
        a = 15'($urandom);
      issue(a, $urandom_range(0, 3));
    end

    for (int k = 0; k < 18; k++)
      issue({3'(k), 12'hA40 + 12'(k % 4)}, 0);
    chk("misses saturated", misses, (1 << CW) - 1);

    repeat (4) @(negedge clk);
    chk("pending mem words", exp_mem.size(), 0);
    chk("pending fills", exp_fill.size(), 0);
    chk("pending readies", exp_rdy.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
